// File: rtl/router_op_lut_stat_cntrs.sv
// Parametrised event statistics counters on the UDP register ring.
// Ring outputs are the inputs delayed one clock; our requests are acked with read data or write echo.
module router_op_lut_stat_cntrs #(
    parameter int NUM_CNTRS          = 10,
    parameter int CNTR_WIDTH         = 32,
    parameter int UDP_REG_ADDR_WIDTH = 23,
    parameter int WORD_BITS          = 7,
    parameter logic [UDP_REG_ADDR_WIDTH-WORD_BITS-1:0] BLOCK_TAG = 'h2,
    parameter int UDP_REG_SRC_WIDTH  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          reg_req_i,
    input  logic                          reg_ack_i,
    input  logic                          reg_rd_wr_L_i,
    input  logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_i,
    input  logic [31:0]                   reg_data_i,
    input  logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_i,
    output logic                          reg_req_o,
    output logic                          reg_ack_o,
    output logic                          reg_rd_wr_L_o,
    output logic [UDP_REG_ADDR_WIDTH-1:0] reg_addr_o,
    output logic [31:0]                   reg_data_o,
    output logic [UDP_REG_SRC_WIDTH-1:0]  reg_src_o,
    input  logic [NUM_CNTRS-1:0]          event_pulse_i,
    output logic [NUM_CNTRS-1:0]          cntr_overflow_o
);

    logic [CNTR_WIDTH-1:0] cnt_q    [NUM_CNTRS];
    logic [CNTR_WIDTH-1:0] cnt_d    [NUM_CNTRS];
    logic [31:0]           shadow_q [NUM_CNTRS];
    logic [31:0]           shadow_d [NUM_CNTRS];
    logic [2:0]            ctrl_q, ctrl_d;
    logic [NUM_CNTRS-1:0]  status_q, status_d;
    logic [31:0]           rd_data;
    logic                  ours, rd_req, wr_req;
    logic [WORD_BITS-1:0]  idx;

    assign ours   = reg_req_i && !reg_ack_i
                    && (reg_addr_i[UDP_REG_ADDR_WIDTH-1:WORD_BITS] == BLOCK_TAG);
    assign rd_req = ours && reg_rd_wr_L_i;
    assign wr_req = ours && !reg_rd_wr_L_i;
    assign idx    = reg_addr_i[WORD_BITS-1:0];
    assign cntr_overflow_o = status_q;

    always_comb begin
        logic [63:0]          ext;
        logic                 lo_hit, ev_on;
        logic [NUM_CNTRS-1:0] ovf, clr;
        ext      = '0;
        lo_hit   = 1'b0;
        ev_on    = 1'b0;
        ovf      = '0;
        clr      = '0;
        rd_data  = 32'hDEAD_BEEF;
        ctrl_d   = ctrl_q;
        if (idx == WORD_BITS'(0)) rd_data = {29'd0, ctrl_q};
        if (idx == WORD_BITS'(1)) rd_data = 32'(status_q);
        if (wr_req && idx == WORD_BITS'(0)) ctrl_d = reg_data_i[2:0];
        if (wr_req && idx == WORD_BITS'(1)) clr = reg_data_i[NUM_CNTRS-1:0];
        for (int i = 0; i < NUM_CNTRS; i++) begin
            ext         = 64'(cnt_q[i]);
            lo_hit      = (idx == WORD_BITS'(2*i + 2));
            ev_on       = event_pulse_i[i] && !ctrl_q[2];
            cnt_d[i]    = cnt_q[i];
            shadow_d[i] = shadow_q[i];
            if (lo_hit) rd_data = ext[31:0];
            if (idx == WORD_BITS'(2*i + 3)) rd_data = shadow_q[i];
            if (rd_req && lo_hit) shadow_d[i] = ext[63:32];
            // Software access to the low word takes priority over a same-cycle event
            if (wr_req && lo_hit) begin
                cnt_d[i] = CNTR_WIDTH'(reg_data_i);
            end else if (rd_req && lo_hit && ctrl_q[1]) begin
                cnt_d[i] = ev_on ? CNTR_WIDTH'(1) : '0;
            end else if (ev_on) begin
                if (&cnt_q[i]) begin
                    ovf[i]   = 1'b1;
                    cnt_d[i] = ctrl_q[0] ? cnt_q[i] : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNTR_WIDTH'(1);
                end
            end
        end
        status_d = (status_q & ~clr) | ovf;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q   <= '0;
            status_q <= '0;
            for (int i = 0; i < NUM_CNTRS; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            for (int i = 0; i < NUM_CNTRS; i++) begin
                cnt_q[i]    <= cnt_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            reg_req_o     <= 1'b0;
            reg_ack_o     <= 1'b0;
            reg_rd_wr_L_o <= 1'b0;
            reg_addr_o    <= '0;
            reg_data_o    <= '0;
            reg_src_o     <= '0;
        end else begin
            reg_req_o     <= reg_req_i;
            reg_ack_o     <= reg_ack_i | ours;
            reg_rd_wr_L_o <= reg_rd_wr_L_i;
            reg_addr_o    <= reg_addr_i;
            reg_data_o    <= rd_req ? rd_data : reg_data_i;
            reg_src_o     <= reg_src_i;
        end
    end

endmodule
